// File: rtl/mc_pkg.sv
// ============================================================================
// Module      : mc_pkg
// Description : Shared types and constants for the multi-cycle RV32I control
//               unit: FSM states, instruction classes, opcodes, ALU op codes
//               and the opcode classifier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

   // Controller state encoding
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_FAULT  = 3'd6
   } state_t;

   // Instruction class latched in DECODE
   typedef enum logic [2:0] {
      CLS_R       = 3'd0,
      CLS_I       = 3'd1,
      CLS_LW      = 3'd2,
      CLS_SW      = 3'd3,
      CLS_BEQ     = 3'd4,
      CLS_ILLEGAL = 3'd5
   } iclass_t;

   // RV32I major opcodes handled by this controller
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   // Encodings understood by the downstream ALU controller
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // Map a major opcode to its class; BEQ is only legal when branches are on
   function automatic iclass_t classify(input logic [6:0] op, input logic en_branch);
      iclass_t c;
      case (op)
         OP_R:    c = CLS_R;
         OP_I:    c = CLS_I;
         OP_LW:   c = CLS_LW;
         OP_SW:   c = CLS_SW;
         OP_BEQ:  c = en_branch ? CLS_BEQ : CLS_ILLEGAL;
         default: c = CLS_ILLEGAL;
      endcase
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// ============================================================================
// Module      : mc_wait_timer
// Description : Counts memory wait cycles and flags the last cycle in which
//               a missing ready must turn into a fault. Disabled (expire tied
//               low) when TIMEOUT is 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic waiting,
   output logic expire
);

   generate
      if (TIMEOUT == 0) begin : g_disabled
         // Timer not present; keep the ports tied off quietly
         logic unused_inputs;
         assign unused_inputs = ^{clk, reset, clear, waiting};
         assign expire        = 1'b0;
      end else begin : g_enabled
         localparam int CW = $clog2(TIMEOUT + 1);
         logic [CW-1:0] count;

         // Wait counter: cleared between transfers, steps on each idle-ready cycle
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               count <= '0;
            end else if (clear) begin
               count <= '0;
            end else if (waiting) begin
               count <= count + CW'(1);
            end
         end

         // Last allowed cycle still without ready; a ready here never expires
         assign expire = waiting && (count == CW'(TIMEOUT - 1));
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
// Module      : mc_controller
// Description : Multi-cycle RV32I control unit. FETCH/DECODE/EXEC/MEM/WB FSM
//               sharing one memory port through a req/ready handshake, with
//               memory timeout fault, optional BEQ and a retired-instruction
//               counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_controller
   import mc_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter int TIMEOUT   = 16,
   parameter bit EN_BRANCH = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             i_or_d,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             alu_src,
   output logic [1:0]       alu_op,
   output logic             mem2reg,
   output logic             reg_write,
   output logic             fault,
   output logic [CNT_W-1:0] instret
);

   state_t  state;
   state_t  state_nxt;
   iclass_t cls;
   iclass_t decoded;
   logic    retire;
   logic    in_xfer;
   logic    waiting;
   logic    timer_clear;
   logic    expire;

   assign decoded = classify(opcode, EN_BRANCH);

   // Timer inputs come straight from the registered state so the timer never
   // sees the next-state logic. Any cycle outside a transfer, or a cycle that
   // completes one, leaves the counter at zero for the next FETCH/MEM entry.
   assign in_xfer     = (state == ST_FETCH) || (state == ST_MEM);
   assign waiting     = in_xfer && !mem_ready;
   assign timer_clear = !in_xfer || mem_ready;

   mc_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clear),
      .waiting (waiting),
      .expire  (expire)
   );

   // State register; reset returns to IDLE immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Instruction class captured while the opcode is decoded
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cls <= CLS_R;
      end else if (state == ST_DECODE) begin
         cls <= decoded;
      end
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instret <= '0;
      end else if (retire) begin
         instret <= instret + CNT_W'(1);
      end
   end

   // Next-state and strobe decode from registered state and latched class
   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      i_or_d    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      alu_src   = 1'b0;
      alu_op    = ALU_ADD;
      mem2reg   = 1'b0;
      reg_write = 1'b0;
      fault     = 1'b0;
      retire    = 1'b0;

      case (state)
         ST_IDLE: begin
            state_nxt = ST_FETCH;
         end

         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               state_nxt = ST_DECODE;
            end else if (expire) begin
               state_nxt = ST_FAULT;
            end
         end

         ST_DECODE: begin
            state_nxt = (decoded == CLS_ILLEGAL) ? ST_FAULT : ST_EXEC;
         end

         ST_EXEC: begin
            case (cls)
               CLS_R: begin
                  alu_op    = ALU_FUNCT;
                  state_nxt = ST_WB;
               end
               CLS_I: begin
                  alu_src   = 1'b1;
                  alu_op    = ALU_FUNCT;
                  state_nxt = ST_WB;
               end
               CLS_LW, CLS_SW: begin
                  alu_src   = 1'b1;
                  alu_op    = ALU_ADD;
                  state_nxt = ST_MEM;
               end
               CLS_BEQ: begin
                  alu_op    = ALU_SUB;
                  pc_src    = 1'b1;
                  pc_write  = zero;
                  retire    = 1'b1;
                  state_nxt = ST_FETCH;
               end
               default: begin
                  state_nxt = ST_FAULT;
               end
            endcase
         end

         ST_MEM: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
            mem_we  = (cls == CLS_SW);
            if (mem_ready) begin
               if (cls == CLS_SW) begin
                  retire    = 1'b1;
                  state_nxt = ST_FETCH;
               end else begin
                  state_nxt = ST_WB;
               end
            end else if (expire) begin
               state_nxt = ST_FAULT;
            end
         end

         ST_WB: begin
            reg_write = 1'b1;
            mem2reg   = (cls == CLS_LW);
            retire    = 1'b1;
            state_nxt = ST_FETCH;
         end

         ST_FAULT: begin
            fault = 1'b1;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// Module      : tb_mc_controller
// Description : Scoreboard bench for mc_controller. Instruction-level model
//               predicts the cycle of every visible event; a negedge monitor
//               pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_controller;

   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_I   = 7'b0010011;
   localparam logic [6:0] OPC_LW  = 7'b0000011;
   localparam logic [6:0] OPC_SW  = 7'b0100011;
   localparam logic [6:0] OPC_BEQ = 7'b1100011;

   localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4;
   localparam int K_WAIT = 0, K_XFER = 1, K_ALU = 2, K_BR = 3, K_WB = 4, K_ODD = 5;

   typedef struct {
      int         kind;
      int         cyc;
      logic [3:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset_a, reset_b;
   logic [6:0] opcode;
   logic       zero, mem_ready;

   logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src;
   logic [1:0] alu_op;
   logic       mem2reg, reg_write, fault;
   logic [2:0] instret;

   logic        mem_req_b, mem_we_b, i_or_d_b, ir_write_b, pc_write_b, pc_src_b, alu_src_b;
   logic [1:0]  alu_op_b;
   logic        mem2reg_b, reg_write_b, fault_b;
   logic [31:0] instret_b;

   int  cyc     = 0;
   int  tests   = 0;
   int  fails   = 0;
   int  retired = 0;
   bit  mon_en  = 1'b0;
   ev_t exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mc_controller #(.CNT_W(3), .TIMEOUT(4), .EN_BRANCH(1'b1)) dut (
      .clk(clk), .reset(reset_a), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op),
      .mem2reg(mem2reg), .reg_write(reg_write), .fault(fault), .instret(instret)
   );

   mc_controller #(.CNT_W(32), .TIMEOUT(0), .EN_BRANCH(1'b0)) dut_nobr (
      .clk(clk), .reset(reset_b), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req_b), .mem_we(mem_we_b), .i_or_d(i_or_d_b), .ir_write(ir_write_b),
      .pc_write(pc_write_b), .pc_src(pc_src_b), .alu_src(alu_src_b), .alu_op(alu_op_b),
      .mem2reg(mem2reg_b), .reg_write(reg_write_b), .fault(fault_b), .instret(instret_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_ev(input int kind, input int c, input logic [3:0] d);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input logic [3:0] data);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event: got kind %0d data %b cycle %0d, expected none",
                  kind, data, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.data !== data) begin
            fails++;
            $display("FAIL event: got kind %0d cycle %0d data %b, expected kind %0d cycle %0d data %b",
                     kind, cyc, data, e.kind, e.cyc, e.data);
         end
      end
   endtask

   // Monitor: every visible action of the main DUT becomes an event
   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_req)
            observe(mem_ready ? K_XFER : K_WAIT, {i_or_d, mem_we, ir_write, pc_write});
         if (alu_src || alu_op != 2'b00)
            observe(K_ALU, {1'b0, alu_src, alu_op});
         if (pc_src)
            observe(K_BR, {3'b000, pc_write});
         if (reg_write)
            observe(K_WB, {3'b000, mem2reg});
         if (fault || (!mem_req && (mem_we || i_or_d || ir_write)) ||
             (!mem_req && !pc_src && pc_write) || (!reg_write && mem2reg))
            observe(K_ODD, {fault, mem_we, i_or_d, ir_write});
      end
   end

   // One instruction from its first FETCH cycle: model events, then drive
   task automatic run_instr(input int cls, input int f, input int m, input logic z);
      int         t0;
      int         len;
      logic [6:0] op;
      logic [3:0] alu_d;
      logic       is_mem;
      logic       is_sw;
      t0     = cyc;
      is_mem = (cls == C_LW) || (cls == C_SW);
      is_sw  = (cls == C_SW);
      case (cls)
         C_R:     begin op = OPC_R;   alu_d = 4'b0010; len = f + 4;     end
         C_I:     begin op = OPC_I;   alu_d = 4'b0110; len = f + 4;     end
         C_LW:    begin op = OPC_LW;  alu_d = 4'b0100; len = f + m + 5; end
         C_SW:    begin op = OPC_SW;  alu_d = 4'b0100; len = f + m + 4; end
         default: begin op = OPC_BEQ; alu_d = 4'b0001; len = f + 3;     end
      endcase
      for (int i = 0; i < f; i++) expect_ev(K_WAIT, t0 + i, 4'b0000);
      expect_ev(K_XFER, t0 + f, 4'b0011);
      expect_ev(K_ALU, t0 + f + 2, alu_d);
      if (cls == C_BEQ) expect_ev(K_BR, t0 + f + 2, {3'b000, z});
      if (cls == C_R || cls == C_I) expect_ev(K_WB, t0 + f + 3, 4'b0000);
      if (is_mem) begin
         for (int i = 0; i < m; i++) expect_ev(K_WAIT, t0 + f + 3 + i, {1'b1, is_sw, 2'b00});
         expect_ev(K_XFER, t0 + f + 3 + m, {1'b1, is_sw, 2'b00});
         if (cls == C_LW) expect_ev(K_WB, t0 + f + 4 + m, 4'b0001);
      end
      for (int j = 0; j < len; j++) begin
         opcode = op;
         zero   = z;
         if (j < f)                                   mem_ready = 1'b0;
         else if (j == f)                             mem_ready = 1'b1;
         else if (is_mem && j >= f + 3 && j < f + 3 + m) mem_ready = 1'b0;
         else if (is_mem && j == f + 3 + m)           mem_ready = 1'b1;
         else                                         mem_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      retired++;
      check("instret", 32'(instret), 32'(retired % 8));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cnt;
      reset_a   = 1'b0;
      reset_b   = 1'b0;
      opcode    = 7'd0;
      zero      = 1'b0;
      mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_strobes", 32'({mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
                                  alu_src, alu_op, mem2reg, reg_write, fault}), 32'd0);
      check("reset_instret", 32'(instret), 32'd0);
      check("reset_instret_b", instret_b, 32'd0);

      // Release; ready high during IDLE must be ignored
      mem_ready = 1'b1;
      reset_a   = 1'b1;
      mon_en    = 1'b1;
      @(posedge clk); #1;

      run_instr(C_R, 0, 0, 1'b1);
      for (int i = 0; i < 9; i++)
         run_instr(C_SW, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      run_instr(C_LW, 0, 3, 1'b0);
      run_instr(C_BEQ, 0, 0, 1'b1);
      run_instr(C_BEQ, 0, 0, 1'b0);
      run_instr(C_LW, 3, 3, 1'b1);
      for (int i = 0; i < 50; i++)
         run_instr($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      mon_en = 1'b0;

      // Reset in the middle of a stalled MEM transfer
      opcode    = OPC_LW;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mem_phase", 32'({mem_req, i_or_d, mem_we}), 32'b110);
      #2 reset_a = 1'b0;
      #1;
      check("async_reset_outputs", 32'({mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
                                        alu_src, alu_op, mem2reg, reg_write, fault}), 32'd0);
      check("async_reset_instret", 32'(instret), 32'd0);
      @(posedge clk); #1;
      reset_a = 1'b1;
      check("idle_after_release", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
      check("fetch_after_idle", 32'({mem_req, i_or_d}), 32'b10);

      // Timeout: ready never comes in FETCH
      cnt = 0;
      for (int i = 0; i < 20 && !fault; i++) begin
         if (mem_req) cnt++;
         @(posedge clk); #1;
      end
      check("timeout_req_cycles", 32'(cnt), 32'd4);
      check("timeout_fault", 32'(fault), 32'd1);
      mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("fault_sticky", 32'({fault, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
                                 alu_src, alu_op, mem2reg, reg_write}), 32'h800);

      // Illegal opcode faults after DECODE
      reset_a = 1'b0;
      @(posedge clk); #1;
      reset_a   = 1'b1;
      opcode    = 7'b1111111;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("illegal_decode_no_fault", 32'(fault), 32'd0);
      @(posedge clk); #1;
      check("illegal_fault", 32'(fault), 32'd1);
      check("illegal_instret", 32'(instret), 32'd0);

      // Second instance: no timeout, BEQ illegal
      reset_a   = 1'b0;
      reset_b   = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      repeat (40) @(posedge clk);
      #1;
      check("no_timeout_when_disabled", 32'({fault_b, mem_req_b}), 32'b01);
      opcode    = OPC_BEQ;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      check("nobr_decode", 32'(fault_b), 32'd0);
      @(posedge clk); #1;
      check("nobr_beq_fault", 32'(fault_b), 32'd1);
      check("nobr_instret", instret_b, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mc_controller.md
# mc_controller

Parametrised multi-cycle control unit for the next-generation RV32I core. It replaces the single-cycle opcode decoder with a FETCH/DECODE/EXEC/MEM/WB state machine that shares one memory port through a req/ready handshake. It also provides a memory-timeout fault, an optional BEQ mode and a retired-instruction counter. It sits between the instruction register opcode field and the multi-cycle datapath, driving the existing ALU controller through `alu_op`.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `TIMEOUT`, 16: memory wait limit in cycles; 0 disables the timeout.
- `EN_BRANCH`, 1: 1 treats BEQ (1100011) as legal; 0 treats it as illegal.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `opcode` in 7: IR[6:0]; valid from DECODE onward.
- `zero` in 1: ALU zero flag; sampled in EXEC for BEQ.
- `mem_ready` in 1: memory completes the current transfer this cycle.
- `mem_req` out 1: memory transfer requested.
- `mem_we` out 1: transfer is a write.
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load the IR.
- `pc_write` out 1: update the PC.
- `pc_src` out 1: PC source; 0 = PC+4, 1 = branch target.
- `alu_src` out 1: ALU B-input select; 0 = register, 1 = immediate.
- `alu_op` out 2: to ALU controller; 00 = add, 01 = sub, 10 = decode by funct fields.
- `mem2reg` out 1: writeback source; 1 = memory data.
- `reg_write` out 1: register-file write enable.
- `fault` out 1: sticky fault flag.
- `instret` out CNT_W: count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT. Reset forces IDLE.
- Outputs are decoded from the registered state plus an instruction class latched in DECODE.
- IDLE: all strobes 0. Goes to FETCH on the next edge.
- FETCH: `mem_req`=1, `i_or_d`=0.
  - On `mem_ready`: `ir_write`=1 and `pc_write`=1 (`pc_src`=0), then go to DECODE.
- DECODE: classify `opcode` and latch the class:
  - R = 0110011
  - I = 0010011
  - LW = 0000011
  - SW = 0100011
  - BEQ = 1100011, only if `EN_BRANCH`
  - Any other opcode goes to FAULT; legal opcodes go to EXEC.
- EXEC, per class:
  - R: `alu_src`=0, `alu_op`=10; next WB.
  - I: `alu_src`=1, `alu_op`=10; next WB.
  - LW/SW: `alu_src`=1, `alu_op`=00; next MEM.
  - BEQ: `alu_src`=0, `alu_op`=01; `pc_write`=`zero`, `pc_src`=1; retire and go to FETCH.
- MEM: `mem_req`=1, `i_or_d`=1, `mem_we`=(class==SW).
  - On `mem_ready`: SW retires and goes to FETCH; LW goes to WB.
- WB: `reg_write`=1, `mem2reg`=(class==LW). Retire and go to FETCH.
- FAULT: all strobes 0, `fault`=1. Exit only through reset.
- Retire: `instret` increments by 1 on the transition edge. It wraps from 2^CNT_W−1 to 0.

## Timing
- Reset values: state IDLE; every strobe, `alu_op`, `pc_src`, `mem2reg` and `fault` are 0; `instret` is 0. Reset acts immediately, including mid-transfer.
- Handshake:
  - `mem_req` stays high until `mem_ready` is sampled high at an edge.
  - `mem_ready` is ignored while `mem_req`=0.
  - `mem_we` and `i_or_d` are stable for the whole request.
- Timeout:
  - A wait counter clears on each entry to FETCH or MEM.
  - It increments on each cycle in which `mem_ready`=0.
  - If the counter equals `TIMEOUT`−1 and `mem_ready`=0, the next state is FAULT.
  - `mem_ready` in the last allowed cycle is accepted, so ready wins.
- Latency with zero-wait memory (`mem_ready` high on the first FETCH cycle): R/I 4 cycles, LW 5, SW 4, BEQ 3. Each memory wait cycle adds 1.

## Structure
- Package `mc_pkg` holds:
  - the state enum
  - the instruction-class enum
  - opcode constants
  - `alu_op` encodings (ADD=00, SUB=01, FUNCT=10)
- Sub-module `mc_wait_timer`: parametrised by `TIMEOUT`, with counter width clog2(TIMEOUT+1).
  - Inputs: `clear`, `waiting`.
  - Output: `expire`.
  - `expire` is tied to 0 when `TIMEOUT`=0.

## Test plan
- Reset release, `mem_ready` held 1, opcode 0110011 → states IDLE, FETCH, DECODE, EXEC, WB, FETCH; `reg_write`=1 only in WB; `instret`=1.
- LW with `mem_ready` low for 3 cycles in MEM → `mem_req`=1, `i_or_d`=1 for 4 cycles; WB has `mem2reg`=1; 8 cycles from FETCH to the next FETCH.
- BEQ with `zero`=1, then again with `zero`=0 → `pc_write`=1, `pc_src`=1 in EXEC for the first; `pc_write`=0 for the second; `instret` +1 each time. With `EN_BRANCH`=0 → `fault`=1.
- `TIMEOUT`=4, `mem_ready` never asserted in FETCH → FAULT entered after 4 request cycles; rerun with `mem_ready` in the 4th cycle → accepted, no fault.
- `CNT_W`=3, 9 SW instructions → `instret` reads 1 after wrap; `mem_we`=1 only in MEM.
- Reset asserted mid-MEM → all outputs 0 asynchronously; after release, IDLE then FETCH.
